// File: rtl/read_ddr_fifo_pkg.sv
// rtl/read_ddr_fifo_pkg.sv - shared width, depth and threshold defaults for the wide-write/narrow-read FIFO
package read_ddr_fifo_pkg;

    localparam int WR_DATA_WIDTH_DEF    = 256;
    localparam int WR_DEPTH_WIDTH_DEF   = 10;
    localparam int RD_DATA_WIDTH_DEF    = 32;
    localparam int RD_DEPTH_WIDTH_DEF   = 13;
    localparam int ALMOST_FULL_NUM_DEF  = 1020;
    localparam int ALMOST_EMPTY_NUM_DEF = 4;
    localparam int LANES                = WR_DATA_WIDTH_DEF / RD_DATA_WIDTH_DEF;

endpackage

// File: rtl/read_ddr_fifo_ram.sv
// rtl/read_ddr_fifo_ram.sv - simple dual-port RAM, full-width write port and synchronous read port
module read_ddr_fifo_ram #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset so the read word is defined out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/read_ddr_fifo.sv
// rtl/read_ddr_fifo.sv - FIFO taking wide words and returning them one narrow lane at a time, lane 0 first
module read_ddr_fifo
    import read_ddr_fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = WR_DATA_WIDTH_DEF,
    parameter int WR_DEPTH_WIDTH   = WR_DEPTH_WIDTH_DEF,
    parameter int RD_DATA_WIDTH    = RD_DATA_WIDTH_DEF,
    parameter int RD_DEPTH_WIDTH   = RD_DEPTH_WIDTH_DEF,
    parameter int ALMOST_FULL_NUM  = ALMOST_FULL_NUM_DEF,
    parameter int ALMOST_EMPTY_NUM = ALMOST_EMPTY_NUM_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int LW = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] AF_THR   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [RD_DEPTH_WIDTH:0] AE_THR   = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [WR_DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d;
    logic [RD_DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d;
    logic [WR_DEPTH_WIDTH:0]  wr_level_q, wr_level_d;
    logic [RD_DEPTH_WIDTH:0]  rd_level_q, rd_level_d;
    logic                     wr_full_q, rd_empty_q, almost_full_q, almost_empty_q;
    logic [LW-1:0]            lane_q;
    logic                     wr_accept, rd_accept;
    logic [WR_DATA_WIDTH-1:0] ram_rd_data;

    assign wr_accept = wr_en & ~wr_full_q;
    assign rd_accept = rd_en & ~rd_empty_q;

    // The read pointer counts narrow words: its upper bits address the RAM, the low LW bits pick the lane.
    // Both pointers carry one extra MSB, so the difference stays unambiguous across wrap.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{WR_DEPTH_WIDTH{1'b0}}, wr_accept};
        rd_ptr_d   = rd_ptr_q + {{RD_DEPTH_WIDTH{1'b0}}, rd_accept};
        rd_level_d = {wr_ptr_d, {LW{1'b0}}} - rd_ptr_d;
        wr_level_d = wr_ptr_d - rd_ptr_d[RD_DEPTH_WIDTH:LW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            wr_level_q     <= '0;
            rd_level_q     <= '0;
            wr_full_q      <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            lane_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_level_q     <= wr_level_d;
            rd_level_q     <= rd_level_d;
            wr_full_q      <= (wr_level_d == FULL_LVL);
            rd_empty_q     <= (rd_level_d == '0);
            almost_full_q  <= (wr_level_d >= AF_THR);
            almost_empty_q <= (rd_level_d <= AE_THR);
            if (rd_accept) begin
                lane_q <= rd_ptr_q[LW-1:0];
            end
        end
    end

    read_ddr_fifo_ram #(
        .DATA_W (WR_DATA_WIDTH),
        .ADDR_W (WR_DEPTH_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[WR_DEPTH_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[RD_DEPTH_WIDTH-1:LW]),
        .rd_data_o (ram_rd_data)
    );

    // RAM output and lane register both only move on an accepted read, so rd_data holds otherwise.
    assign rd_data        = ram_rd_data[int'(lane_q)*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    assign wr_full        = wr_full_q;
    assign rd_empty       = rd_empty_q;
    assign almost_full    = almost_full_q;
    assign almost_empty   = almost_empty_q;
    assign wr_water_level = wr_level_q;
    assign rd_water_level = rd_level_q;

endmodule

// File: tb/tb_read_ddr_fifo.sv
// tb/tb_read_ddr_fifo.sv - scoreboard bench for read_ddr_fifo
module tb_read_ddr_fifo;
    import read_ddr_fifo_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] wr_data = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         wr_full, almost_full, rd_empty, almost_empty;
    logic [10:0]  wr_water_level;
    logic [13:0]  rd_water_level;
    logic [31:0]  rd_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;
    bit          fire_prev = 1'b0;
    logic [255:0] w;

    read_ddr_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int mdl_wlvl();
        return (mdl.size() + 7) / 8;
    endfunction

    function automatic logic [255:0] fill_word(input int k);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'hA000_0000 + 32'(k * 8 + j);
        return r;
    endfunction

    // Called just after a rising edge; model is updated after the edge that performs the operation.
    task automatic op(input bit we, input bit re, input logic [255:0] d);
        bit wacc, racc;
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        wacc = we && (mdl_wlvl() < 1024);
        racc = re && (mdl.size() > 0);
        @(posedge clk);
        #1;
        if (racc) exp_q.push_back(mdl.pop_front());
        if (wacc) for (int j = 0; j < LANES; j++) mdl.push_back(d[j*32 +: 32]);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl.delete();
        exp_q.delete();
        last_rd = '0;
        #1;
        check("rst_async_empty", rd_empty, 1'b1);
        check("rst_async_level", rd_water_level, 0);
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = fill_word(9999);
        repeat (3) @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: compares returned words and all status against the model at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (fire_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got 0x%0h, want no read", rd_data);
                end else begin
                    last_rd = exp_q.pop_front();
                    check("rd_data", rd_data, last_rd);
                end
            end else begin
                check("rd_hold", rd_data, last_rd);
            end
            check("rd_level", rd_water_level, 32'(mdl.size()));
            check("wr_level", wr_water_level, 32'(mdl_wlvl()));
            check("rd_empty", rd_empty, 32'(mdl.size() == 0));
            check("wr_full", wr_full, 32'(mdl_wlvl() == 1024));
            check("almost_full", almost_full, 32'(mdl_wlvl() >= ALMOST_FULL_NUM_DEF));
            check("almost_empty", almost_empty, 32'(mdl.size() <= ALMOST_EMPTY_NUM_DEF));
            fire_prev = rst_n && rd_en && (mdl.size() > 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_empty", rd_empty, 1);
        check("reset_almost_empty", almost_empty, 1);
        check("reset_wr_full", wr_full, 0);
        check("reset_almost_full", almost_full, 0);
        check("reset_wr_level", wr_water_level, 0);
        check("reset_rd_level", rd_water_level, 0);
        check("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One write, then eight lane reads in order
        w = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        op(1'b1, 1'b0, w);
        check("one_wr_level", wr_water_level, 1);
        check("one_rd_level", rd_water_level, 8);
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, '0);
            check("lane_order", rd_data, 32'(i + 1));
            check("one_wr_level_during", wr_water_level, (i < 7) ? 32'd1 : 32'd0);
        end
        op(1'b0, 1'b0, '0);
        check("one_empty_after", rd_empty, 1);

        // Fill with one extra write
        for (int k = 0; k < 1025; k++) begin
            op(1'b1, 1'b0, fill_word(k));
            if (k == 1018) check("af_below", almost_full, 0);
            if (k == 1019) check("af_at_1020", almost_full, 1);
        end
        check("fill_full", wr_full, 1);
        check("fill_wr_level", wr_water_level, 1024);
        check("fill_rd_level", rd_water_level, 8192);

        // Drain with one extra read
        for (int i = 0; i < 8193; i++) begin
            op(1'b0, 1'b1, '0);
            if (i == 8186) check("ae_above", almost_empty, 0);
            if (i == 8187) check("ae_at_4", almost_empty, 1);
            if (i == 8191) check("drain_last", rd_data, 32'hA000_1FFF);
        end
        op(1'b0, 1'b0, '0);
        check("drain_empty", rd_empty, 1);
        check("drain_hold", rd_data, 32'hA000_1FFF);

        // Simultaneous write and read at level 8
        op(1'b1, 1'b0, fill_word(2000));
        op(1'b1, 1'b1, fill_word(2001));
        check("simul_rd_level", rd_water_level, 15);
        check("simul_wr_level", wr_water_level, 2);
        for (int i = 0; i < 15; i++) op(1'b0, 1'b1, '0);
        op(1'b0, 1'b0, '0);
        check("simul_drained", rd_empty, 1);

        // Reset at half fill
        for (int k = 0; k < 512; k++) op(1'b1, 1'b0, fill_word(5000 + k));
        check("half_wr_level", wr_water_level, 512);
        do_reset();
        check("midrst_empty", rd_empty, 1);
        check("midrst_wr_level", wr_water_level, 0);
        w = fill_word(7000);
        op(1'b1, 1'b0, w);
        op(1'b0, 1'b1, '0);
        check("midrst_first", rd_data, 32'hA000_0000 + 32'(7000 * 8));
        for (int i = 0; i < 7; i++) op(1'b0, 1'b1, '0);
        op(1'b0, 1'b0, '0);
        op(1'b0, 1'b0, '0);
        check("final_sb_empty", 32'(exp_q.size()), 0);
        check("final_rd_empty", rd_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/read_ddr_fifo.md
READ_DDR_FIFO -- requirements
Module: read_ddr_fifo

Interface
REQ-001 SHALL have parameter WR_DATA_WIDTH, default 256, write word width in bits.
REQ-002 SHALL have parameter WR_DEPTH_WIDTH, default 10, log2 of write depth (1024 words).
REQ-003 SHALL have parameter RD_DATA_WIDTH, default 32, read word width in bits (WR_DATA_WIDTH/RD_DATA_WIDTH = 8 lanes).
REQ-004 SHALL have parameter RD_DEPTH_WIDTH, default 13, log2 of read depth (8192 words).
REQ-005 SHALL have parameter ALMOST_FULL_NUM, default 1020, write-side threshold.
REQ-006 SHALL have parameter ALMOST_EMPTY_NUM, default 4, read-side threshold.
REQ-007 SHALL use one clock and an asynchronous, active-low reset, as these ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have the remaining ports:
- wr_data  in  256  write word.
- wr_en  in  1  write request.
- wr_full  out  1  no free write slot.
- wr_water_level  out  11  occupied write slots.
- almost_full  out  1  fill-level flag.
- rd_en  in  1  read request.
- rd_data  out  32  read word.
- rd_empty  out  1  no read word available.
- rd_water_level  out  14  available read words.
- almost_empty  out  1  drain-level flag.

Function
REQ-009 SHALL store 256-bit words and return them as eight 32-bit words, lane 0 (bits 31:0) first, lane 7 (bits 255:224) last.
REQ-010 SHALL keep rd_water_level = number of unread 32-bit words, in the range 0..8192.
REQ-011 SHALL keep wr_water_level = ceil(rd_water_level/8); a partly read write word still occupies its slot.
REQ-012 SHALL accept a write when wr_en=1 and wr_full=0; wr_en while full SHALL be ignored and SHALL leave the contents unchanged.
REQ-013 SHALL accept a read when rd_en=1 and rd_empty=0; rd_data SHALL present that word on the cycle after the accepted rd_en (1-cycle latency, no output register).
REQ-014 SHALL ignore rd_en while empty; rd_data SHALL then hold its last value.
REQ-015 SHALL perform an accepted write and an accepted read in the same cycle together; the levels SHALL change by +8-1 read words.
REQ-016 SHALL drive wr_full=1 iff wr_water_level==1024 and rd_empty=1 iff rd_water_level==0, both from registered state (no combinational path from the enables).
REQ-017 SHALL drive almost_full=1 iff wr_water_level>=ALMOST_FULL_NUM and almost_empty=1 iff rd_water_level<=ALMOST_EMPTY_NUM.
REQ-018 SHALL wrap the write pointer (10 bits) and read pointer (13 bits) modulo depth, using the extra MSB to tell full from empty.
REQ-019 SHALL update the flags and levels on the clock edge after an accepted operation.

Reset
REQ-020 SHALL, on rst_n=0 and at any time, asynchronously clear the pointers and levels to 0 and set rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
REQ-021 SHALL discard the stored contents on reset mid-operation; enables SHALL be ignored while rst_n=0.
REQ-022 SHALL not depend on any global-reset primitive; rst_n SHALL be the only reset.

Structure
REQ-023 SHALL place the width, depth and threshold defaults and the lane count in the shared package read_ddr_fifo_pkg.
REQ-024 SHALL use one sub-module, read_ddr_fifo_ram: a simple dual-port 1024x256 RAM with a 256-bit write port and a synchronous read port; lane selection SHALL happen in the parent.

Verification
REQ-025 SHALL cover reset: rst_n=0 -> rd_empty=1, almost_empty=1, wr_full=0, both levels 0, rd_data=0.
REQ-026 SHALL cover one write then reads: write word 0x...0008_0007_0006_0005_0004_0003_0002_0001, then 8 rd_en -> rd_data 1,2,...,8 each one cycle after its rd_en; after the last read rd_empty=1; wr_water_level reads 1 until the 8th read is accepted.
REQ-027 SHALL cover fill: 1025 consecutive writes -> 1024 accepted, wr_full=1, wr_water_level=1024, rd_water_level=8192; almost_full rises at level 1020; the 1025th word is absent from the read-back.
REQ-028 SHALL cover drain: 8193 consecutive reads after the fill -> 8192 words returned in order, then rd_empty=1; almost_empty rises at rd_water_level=4; the extra read leaves rd_data unchanged.
REQ-029 SHALL cover simultaneous operation: at level 8, write and read in the same cycle -> rd_water_level=15, wr_water_level=2.
REQ-030 SHALL cover mid-operation reset: rst_n pulsed low at half fill -> immediately empty; the next written word is read back first.
